// File: rtl/jpeg_quant_pkg.sv
// Shared constants and types for the streaming JPEG quantizer.
package jpeg_quant_pkg;

  localparam int BLOCK_SIZE = 64;

  typedef logic [5:0] coef_idx_t;

  // Reciprocal of divisor 1, i.e. a pass-through table entry.
  function automatic logic [31:0] default_recip(input int shift);
    return 32'd1 << shift;
  endfunction

endpackage

// File: rtl/quant_recip_table.sv
// NUM_TABLES x 64 reciprocal register file: one write port, one combinational read port.
module quant_recip_table
  import jpeg_quant_pkg::*;
#(
  parameter int NUM_TABLES = 2,
  parameter int SHIFT      = 15,
  parameter int RECIP_W    = SHIFT + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [$clog2(NUM_TABLES)-1:0] wr_sel,
  input  coef_idx_t                     wr_addr,
  input  logic [RECIP_W-1:0]            wr_data,
  input  logic [$clog2(NUM_TABLES)-1:0] rd_sel,
  input  coef_idx_t                     rd_addr,
  output logic [RECIP_W-1:0]            rd_data
);

  localparam logic [RECIP_W-1:0] DEFAULT_RECIP = RECIP_W'(default_recip(SHIFT));

  logic [RECIP_W-1:0] mem [NUM_TABLES][BLOCK_SIZE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NUM_TABLES; t++) begin
        for (int e = 0; e < BLOCK_SIZE; e++) begin
          mem[t][e] <= DEFAULT_RECIP;
        end
      end
    end else if (we && (int'(wr_sel) < NUM_TABLES)) begin
      mem[wr_sel][wr_addr] <= wr_data;
    end
  end

  // A same-cycle write is not visible here until after the edge (old value wins).
  always_comb begin
    rd_data = DEFAULT_RECIP;
    if (int'(rd_sel) < NUM_TABLES) rd_data = mem[rd_sel][rd_addr];
  end

endmodule

// File: rtl/jpeg_quantizer_stream.sv
// Streaming 3-stage quantizer: |z| * recip, round half away from zero, saturate,
// with per-block table selection and block index tracking.
module jpeg_quantizer_stream
  import jpeg_quant_pkg::*;
#(
  parameter int IN_W       = 12,
  parameter int OUT_W      = 11,
  parameter int NUM_TABLES = 2,
  parameter int SHIFT      = 15,
  parameter int RECIP_W    = SHIFT + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [IN_W-1:0]        in_data,
  input  logic                          in_sop,
  input  logic [$clog2(NUM_TABLES)-1:0] in_tsel,
  input  logic                          tbl_we,
  input  logic [$clog2(NUM_TABLES)-1:0] tbl_sel,
  input  coef_idx_t                     tbl_addr,
  input  logic [RECIP_W-1:0]            tbl_wdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_W-1:0]       out_data,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic                          out_sat,
  output logic                          err_sync
);

  localparam int TSEL_W = $clog2(NUM_TABLES);
  localparam int PW     = IN_W + RECIP_W;
  localparam logic [PW:0] RND     = (PW+1)'(1) << (SHIFT - 1);
  localparam logic [PW:0] POS_LIM = ((PW+1)'(1) << (OUT_W - 1)) - (PW+1)'(1);
  localparam logic [PW:0] NEG_LIM = (PW+1)'(1) << (OUT_W - 1);
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // Handshake: input transfers on in_valid && in_ready; output transfers on
  // out_valid && out_ready. The whole pipeline moves together only when the
  // output register is empty or being drained, so in_ready equals advance.
  logic             advance, xfer, resync;
  coef_idx_t        idx, eff_idx;
  logic [TSEL_W-1:0] tsel_q, tsel_eff;
  logic [RECIP_W-1:0] rd_recip;
  logic [IN_W-1:0]  in_abs;

  always_comb begin
    advance  = !out_valid || out_ready;
    in_ready = advance;
    xfer     = in_valid && advance;
    resync   = xfer && in_sop && (idx != '0);
    eff_idx  = in_sop ? '0 : idx;
    tsel_eff = (eff_idx == '0) ? in_tsel : tsel_q;
    in_abs   = in_data[IN_W-1] ? -in_data : in_data;
  end

  quant_recip_table #(
    .NUM_TABLES(NUM_TABLES),
    .SHIFT     (SHIFT),
    .RECIP_W   (RECIP_W)
  ) u_table (
    .clk    (clk),
    .rst    (rst),
    .we     (tbl_we),
    .wr_sel (tbl_sel),
    .wr_addr(tbl_addr),
    .wr_data(tbl_wdata),
    .rd_sel (tsel_eff),
    .rd_addr(eff_idx),
    .rd_data(rd_recip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      tsel_q   <= '0;
      err_sync <= 1'b0;
    end else begin
      err_sync <= resync;
      if (xfer) begin
        idx    <= eff_idx + coef_idx_t'(1);
        tsel_q <= tsel_eff;
      end
    end
  end

  logic               s1_valid, s1_sign, s1_first, s1_last;
  logic [IN_W-1:0]    s1_mag;
  logic [RECIP_W-1:0] s1_recip;
  logic               s2_valid, s2_sign, s2_first, s2_last;
  logic [PW-1:0]      s2_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_mag   <= '0;
      s1_recip <= '0;
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_prod  <= '0;
    end else if (advance) begin
      s1_valid <= xfer;
      s1_sign  <= in_data[IN_W-1];
      s1_first <= (eff_idx == coef_idx_t'(0));
      s1_last  <= (eff_idx == coef_idx_t'(BLOCK_SIZE - 1));
      s1_mag   <= in_abs;
      s1_recip <= rd_recip;
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_prod  <= PW'(s1_mag) * PW'(s1_recip);
    end
  end

  logic [PW:0]      sum, mag;
  logic [OUT_W-1:0] mag_o, data_c;
  logic             sat_c;

  // Rounding is applied to the magnitude, so halves round away from zero and
  // a zero magnitude can never become a negative zero.
  always_comb begin
    sum    = (PW+1)'(s2_prod) + RND;
    mag    = sum >> SHIFT;
    mag_o  = mag[OUT_W-1:0];
    sat_c  = s2_sign ? (mag > NEG_LIM) : (mag > POS_LIM);
    data_c = s2_sign ? -mag_o : mag_o;
    if (sat_c) data_c = s2_sign ? OUT_MIN : OUT_MAX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_sat   <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_valid;
      out_data  <= s2_valid ? data_c : '0;
      out_sop   <= s2_valid && s2_first;
      out_eop   <= s2_valid && s2_last;
      out_sat   <= s2_valid && sat_c;
    end
  end

endmodule

// File: tb/tb_jpeg_quantizer_stream.sv
// Directed-vector bench for jpeg_quantizer_stream with hand-computed expectations.
module tb_jpeg_quantizer_stream;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready, in_sop;
  logic signed [11:0] in_data;
  logic [0:0]         in_tsel;
  logic               tbl_we;
  logic [0:0]         tbl_sel;
  logic [5:0]         tbl_addr;
  logic [15:0]        tbl_wdata;
  logic               out_valid, out_ready, out_sop, out_eop, out_sat, err_sync;
  logic signed [10:0] out_data;

  jpeg_quantizer_stream dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sop   (in_sop),
    .in_tsel  (in_tsel),
    .tbl_we   (tbl_we),
    .tbl_sel  (tbl_sel),
    .tbl_addr (tbl_addr),
    .tbl_wdata(tbl_wdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_sat  (out_sat),
    .err_sync (err_sync)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int err_cnt = 0;
  logic last_acc = 1'b0;
  logic [13:0] exp_q[$];
  logic [13:0] got_q[$];
  int got_cyc[$];

  function automatic logic [13:0] pk(input logic s, input logic e, input logic t, input int d);
    return {s, e, t, 11'(d)};
  endfunction

  // Called at a falling edge with inputs already driven; samples 1ns later.
  task automatic tick();
    #1;
    if (out_valid && out_ready) begin
      got_q.push_back({out_sop, out_eop, out_sat, out_data});
      got_cyc.push_back(cyc);
    end
    last_acc = in_valid && in_ready;
    if (last_acc) acc_cyc = cyc;
    if (err_sync) err_cnt++;
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic signed [11:0] z, input logic sop, input logic tsel);
    int tries;
    in_valid = 1'b1;
    in_data  = z;
    in_sop   = sop;
    in_tsel  = tsel;
    tries    = 0;
    do begin
      tick();
      tries++;
    end while (!last_acc && tries < 50);
    checks++;
    if (!last_acc) begin
      failures++;
      $display("FAIL send_accept: in_ready never seen for z=%0d", z);
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wr_entry(input logic sel, input logic [5:0] addr, input logic [15:0] val);
    tbl_we    = 1'b1;
    tbl_sel   = sel;
    tbl_addr  = addr;
    tbl_wdata = val;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic clear_obs();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    err_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_tsel = '0;
    tbl_we = 1'b0; tbl_sel = '0; tbl_addr = '0; tbl_wdata = '0;
    out_ready = 1'b1;
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 11'sd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    checks++; if ({out_sop, out_eop, out_sat} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {out_sop, out_eop, out_sat}); end
    checks++; if (err_sync !== 1'b0) begin failures++; $display("FAIL reset_err_sync got=%b exp=0", err_sync); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // q=16 at table0[0]: 100 -> 6 and -100 -> -6 at the start of two blocks.
  task automatic test_latency();
    int first_acc;
    wr_entry(1'b0, 6'd0, 16'd2048);
    clear_obs();
    for (int b = 0; b < 2; b++) begin
      send((b == 0) ? 12'sd100 : -12'sd100, 1'b1, 1'b0);
      if (b == 0) first_acc = acc_cyc;
      for (int i = 1; i < 64; i++) send(12'sd0, 1'b0, 1'b0);
      exp_q.push_back(pk(1'b1, 1'b0, 1'b0, (b == 0) ? 6 : -6));
      for (int i = 1; i < 63; i++) exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 0));
      exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 0));
    end
    drain(6);
    checks++; if (got_q.size() !== 128) begin failures++; $display("FAIL latency_count got=%0d exp=128", got_q.size()); end
    for (int i = 0; i < 128 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL latency_out[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    if (got_cyc.size() > 0) begin
      checks++;
      if (got_cyc[0] - first_acc !== 3) begin failures++; $display("FAIL latency_cycles got=%0d exp=3", got_cyc[0] - first_acc); end
    end
    checks++; if (err_cnt !== 0) begin failures++; $display("FAIL latency_err_sync got=%0d exp=0", err_cnt); end
  endtask

  task automatic check_block(input string name);
    checks++; if (got_q.size() !== 64) begin failures++; $display("FAIL %s_count got=%0d exp=64", name, got_q.size()); end
    for (int i = 0; i < 64 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL %s_out[%0d] got=%h exp=%h", name, i, got_q[i], exp_q[i]); end
    end
  endtask

  // table0[0..2] = q16: -8 -> -1, 7 -> 0, 0 -> 0; remaining entries q1 pass 5.
  task automatic test_rounding();
    wr_entry(1'b0, 6'd1, 16'd2048);
    wr_entry(1'b0, 6'd2, 16'd2048);
    clear_obs();
    send(-12'sd8, 1'b1, 1'b0);
    send(12'sd7, 1'b0, 1'b0);
    send(12'sd0, 1'b0, 1'b0);
    for (int i = 3; i < 64; i++) send(12'sd5, 1'b0, 1'b0);
    drain(6);
    exp_q.push_back(pk(1'b1, 1'b0, 1'b0, -1));
    exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 0));
    exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 0));
    for (int i = 3; i < 63; i++) exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 5));
    exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 5));
    check_block("rounding");
  endtask

  // Default table1 (q=1) exercises both clip limits.
  task automatic test_saturation();
    clear_obs();
    send(12'sd2047, 1'b1, 1'b1);
    send(-12'sd2048, 1'b0, 1'b0);
    send(-12'sd1000, 1'b0, 1'b0);
    send(-12'sd1, 1'b0, 1'b0);
    for (int i = 4; i < 64; i++) send(12'sd1, 1'b0, 1'b0);
    drain(6);
    exp_q.push_back(pk(1'b1, 1'b0, 1'b1, 1023));
    exp_q.push_back(pk(1'b0, 1'b0, 1'b1, -1024));
    exp_q.push_back(pk(1'b0, 1'b0, 1'b0, -1000));
    exp_q.push_back(pk(1'b0, 1'b0, 1'b0, -1));
    for (int i = 4; i < 63; i++) exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 1));
    exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 1));
    check_block("saturation");
  endtask

  // table1 all q=8; tsel toggles after the first coefficient and must be ignored.
  task automatic test_stream_tsel();
    int eops;
    for (int i = 0; i < 64; i++) wr_entry(1'b1, 6'(i), 16'd4096);
    clear_obs();
    for (int i = 0; i < 64; i++) send(12'sd64, (i == 0), (i == 0) ? 1'b1 : 1'(i % 2));
    drain(6);
    for (int i = 0; i < 64; i++) exp_q.push_back(pk((i == 0), (i == 63), 1'b0, 8));
    check_block("stream_tsel");
    eops = 0;
    foreach (got_q[i]) if (got_q[i][12]) eops++;
    checks++; if (eops !== 1) begin failures++; $display("FAIL stream_eop_count got=%0d exp=1", eops); end
  endtask

  // z = 8*i with q=8 gives output i; a 5-cycle stall lands after 20 accepts.
  task automatic test_backpressure();
    clear_obs();
    for (int i = 0; i < 64; i++) begin
      if (i == 20) begin
        in_valid = 1'b1; in_data = 12'(8 * i); in_sop = 1'b0; in_tsel = 1'b1;
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          checks++; if (last_acc !== 1'b0) begin failures++; $display("FAIL stall_accept[%0d] got=%b exp=0", s, last_acc); end
          checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", s, in_ready); end
          checks++; if (out_data !== 11'sd17 || out_valid !== 1'b1) begin failures++; $display("FAIL stall_hold[%0d] got=%0d/%b exp=17/1", s, out_data, out_valid); end
        end
        out_ready = 1'b1;
      end
      send(12'(8 * i), (i == 0), 1'b1);
    end
    drain(6);
    for (int i = 0; i < 64; i++) exp_q.push_back(pk((i == 0), (i == 63), 1'b0, i));
    check_block("backpressure");
  endtask

  task automatic test_resync_reset();
    clear_obs();
    for (int i = 0; i < 10; i++) send(12'(8 * i), (i == 0), 1'b1);
    send(12'sd80, 1'b1, 1'b1);
    for (int i = 1; i < 5; i++) send(12'(8 * (10 + i)), 1'b0, 1'b0);
    drain(6);
    checks++; if (err_cnt !== 1) begin failures++; $display("FAIL resync_err_pulses got=%0d exp=1", err_cnt); end
    checks++; if (got_q.size() !== 15) begin failures++; $display("FAIL resync_count got=%0d exp=15", got_q.size()); end
    if (got_q.size() >= 12) begin
      checks++; if (got_q[0] !== pk(1'b1, 1'b0, 1'b0, 0)) begin failures++; $display("FAIL resync_first got=%h exp=%h", got_q[0], pk(1'b1, 1'b0, 1'b0, 0)); end
      checks++; if (got_q[10] !== pk(1'b1, 1'b0, 1'b0, 10)) begin failures++; $display("FAIL resync_sop got=%h exp=%h", got_q[10], pk(1'b1, 1'b0, 1'b0, 10)); end
      checks++; if (got_q[11] !== pk(1'b0, 1'b0, 1'b0, 11)) begin failures++; $display("FAIL resync_next got=%h exp=%h", got_q[11], pk(1'b0, 1'b0, 1'b0, 11)); end
    end
    // Leave the pipeline full, then reset asynchronously between edges.
    for (int i = 0; i < 3; i++) send(12'sd8, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 11'sd0) begin failures++; $display("FAIL midreset_out_data got=%0d exp=0", out_data); end
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
    // No sop on purpose: the counter itself must be back at index 0.
    send(12'sd100, 1'b0, 1'b1);
    send(-12'sd8, 1'b0, 1'b0);
    drain(6);
    checks++; if (got_q.size() !== 2) begin failures++; $display("FAIL postreset_count got=%0d exp=2", got_q.size()); end
    if (got_q.size() >= 2) begin
      checks++; if (got_q[0] !== pk(1'b1, 1'b0, 1'b0, 100)) begin failures++; $display("FAIL postreset_first got=%h exp=%h", got_q[0], pk(1'b1, 1'b0, 1'b0, 100)); end
      checks++; if (got_q[1] !== pk(1'b0, 1'b0, 1'b0, -8)) begin failures++; $display("FAIL postreset_second got=%h exp=%h", got_q[1], pk(1'b0, 1'b0, 1'b0, -8)); end
    end
    checks++; if (err_cnt !== 0) begin failures++; $display("FAIL postreset_err_sync got=%0d exp=0", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_saturation();
    test_stream_tsel();
    test_backpressure();
    test_resync_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
